apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

APB initiator that converts a simple valid/ready request into a two-phase APB transfer (SETUP, then ACCESS). It handles PREADY wait states and bounds them with a timeout. It sits upstream of `UART_APB_Interface`, or of any APB responder in the design, so that a firmware-less controller can program the UART's control and data registers and read them back.

## Interface
- `ADDR_W`, default 32: APB address width.
- `DATA_W`, default 32: APB data width.
- `TIMEOUT`, default 16: maximum number of ACCESS cycles to wait for PREADY; 0 disables the timeout.

- `PCLK` in 1: single clock. All logic is posedge.
- `PRESETn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: transfer address.
- `req_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_W: read data; 0 for writes and for timeouts.
- `rsp_timeout` out 1: transfer was aborted; qualified by `rsp_valid`.
- `busy` out 1: high in SETUP and ACCESS.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB controls.
- `PADDR` out ADDR_W, `PWDATA` out DATA_W: APB address and write data.
- `PRDATA` in DATA_W, `PREADY` in 1: APB responder response.

## Operation
FSM states are IDLE, SETUP and ACCESS.

- **IDLE**
  - `req_ready`=1.
  - On the edge where `req_valid`&&`req_ready`, capture write, addr and wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0.
  - Unconditionally go to ACCESS.
  - Clear the wait counter.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - PREADY=1 at an edge:
    - Transfer completes and the FSM returns to IDLE.
    - For reads, PRDATA is registered into `rsp_rdata`; for writes, `rsp_rdata`=0.
    - `rsp_timeout`=0.
  - PREADY=0, TIMEOUT≠0, and the counter equals TIMEOUT−1:
    - Abort and return to IDLE.
    - `rsp_rdata`=0, `rsp_timeout`=1.
  - Otherwise the counter increments and the FSM stays in ACCESS.
- Counter width is $clog2(TIMEOUT+1), minimum 1. With TIMEOUT=0 the counter never aborts and the FSM waits indefinitely.
- `rsp_valid` is a registered pulse, high for exactly the one cycle after the completing or aborting edge.
  - `rsp_rdata`/`rsp_timeout` hold their values until the next completion.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. They hold their last values while in IDLE and change only on acceptance.
- `req_ready` is low in SETUP and ACCESS. Requests presented there are not accepted; the requester must hold `req_valid` and its payload until accepted.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - FSM = IDLE.
  - PSEL, PENABLE, PWRITE = 0.
  - PADDR, PWDATA = 0.
  - `rsp_valid`, `rsp_timeout` = 0.
  - `rsp_rdata` = 0.
  - `busy` = 0.
  - `req_ready` = 1 (combinational from state).
- Zero-wait-state latency, counting the accept edge as edge 0:
  - PSEL rises after edge 0.
  - PENABLE rises after edge 1.
  - Completion occurs at edge 2.
  - `rsp_valid` is high in the cycle after edge 2, and PSEL/PENABLE are 0 in that same cycle.
- Each PREADY=0 ACCESS cycle adds one cycle of latency.
- A timeout keeps ACCESS asserted for exactly TIMEOUT cycles.
- Back-to-back: the FSM is in IDLE in the same cycle `rsp_valid` is high, so a waiting request is accepted at that edge. Minimum period is 3 cycles per transfer. PSEL drops for exactly one cycle between transfers.
- PREADY is sampled only in ACCESS; PREADY in IDLE or SETUP is ignored.
- Asserting PRESETn=0 mid-transfer:
  - PSEL/PENABLE drop immediately, asynchronously.
  - No `rsp_valid` is issued and the in-flight request is lost.
  - After release, the FSM is in IDLE.
- Simultaneous PREADY=1 and the timeout condition cannot occur, because the timeout requires PREADY=0. Completion always wins on PREADY=1, including on the final allowed cycle.

## Test plan
- **Write, no wait states:** request write addr 0x2, wdata 0x45, PREADY=1.
  - PSEL high for 2 cycles, with PENABLE high in the 2nd.
  - PADDR=0x2 and PWDATA=0x45 are stable throughout.
  - `rsp_valid` pulses 3 cycles after acceptance with `rsp_timeout`=0 and `rsp_rdata`=0.
- **Read with wait states:** request read addr 0x3; the responder holds PREADY=0 for 2 ACCESS cycles, then drives PRDATA=0x54 with PREADY=1.
  - ACCESS lasts 3 cycles.
  - `rsp_rdata`=0x54 and `rsp_valid` arrives 5 cycles after acceptance.
- **Timeout:** TIMEOUT=16, PREADY tied to 0, any request.
  - PENABLE is high for exactly 16 cycles, then PSEL/PENABLE drop.
  - `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - A follow-up request with PREADY=1 completes normally.
- **Back-to-back:** `req_valid` held high with two writes (addr 0x0 data 0xC, then addr 0x2 data 0x45).
  - Second acceptance occurs in the `rsp_valid` cycle of the first.
  - PSEL is low for exactly one cycle between transfers.
  - The request is not accepted during SETUP or ACCESS (`req_ready`=0).
- **Reset mid-ACCESS:** assert PRESETn=0 while PREADY=0 in ACCESS.
  - All outputs go to their reset values without waiting for PCLK.
  - No `rsp_valid` is issued.
  - After release, `req_ready`=1 and a new read completes correctly.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB initiator: valid/ready request in, SETUP/ACCESS transfer out,
// with PREADY wait states bounded by an optional timeout.
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          done;
    logic          abort;

    assign accept = (state_q == IDLE) && req_valid;
    assign done   = (state_q == ACCESS) && PREADY;
    assign abort  = (state_q == ACCESS) && !PREADY &&
                    (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus controls decode straight from state so reset drops them at once.
    always_comb begin
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            SETUP: begin
                PSEL = 1'b1;
                busy = 1'b1;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (accept) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !done && !abort) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= done || abort;
            if (done) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a response scoreboard
// and a small APB responder that inserts a programmable wait count.
module tb_apb_master_ctrl;

    localparam int TO = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        to;
        int          lat;
    } exp_t;

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    logic [31:0] rdata_val;
    int          wait_n;
    logic        hang;
    int          acc_cnt;

    int   checks;
    int   errors;
    exp_t sb[$];

    apb_master_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Responder: counts ACCESS cycles, raises PREADY after wait_n of them.
    always @(posedge PCLK) begin
        acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
    end

    assign PREADY = !hang && (acc_cnt >= wait_n);
    assign PRDATA = rdata_val;

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_rsp(input string tag, input int n);
        exp_t e;
        chk({tag, ":sb_nonempty"}, 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ":rdata"}, 128'(rsp_rdata), 128'(e.rdata));
            chk({tag, ":timeout"}, 128'(rsp_timeout), 128'(e.to));
            chk({tag, ":latency"}, 128'(n), 128'(e.lat));
        end
    endtask

    task automatic xfer(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] exp_rd,
                        input logic exp_to);
        int n;
        int acc;
        int lat;
        int exp_acc;
        wait_n    = waits;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk({tag, ":ready"}, 128'(req_ready), 128'd1);
        lat     = exp_to ? 2 + TO : 3 + waits;
        exp_acc = exp_to ? TO : waits + 1;
        sb.push_back('{exp_rd, exp_to, lat});
        step();
        req_valid = 1'b0;
        chk({tag, ":setup"}, 128'({PSEL, PENABLE, busy, req_ready}),
            128'(4'b1010));
        chk({tag, ":setup_bus"}, 128'({PWRITE, PADDR, PWDATA}),
            128'({w, a, d}));
        n   = 1;
        acc = 0;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
            if (!rsp_valid) begin
                acc++;
                chk({tag, ":access"}, 128'({PSEL, PENABLE, req_ready}),
                    128'(3'b110));
                chk({tag, ":access_bus"}, 128'({PWRITE, PADDR, PWDATA}),
                    128'({w, a, d}));
            end
        end
        chk({tag, ":rsp_seen"}, 128'(rsp_valid), 128'd1);
        pop_rsp(tag, n);
        chk({tag, ":access_len"}, 128'(acc), 128'(exp_acc));
        chk({tag, ":rsp_bus_idle"}, 128'({PSEL, PENABLE, busy, req_ready}),
            128'(4'b0001));
        step();
        chk({tag, ":rsp_pulse"}, 128'(rsp_valid), 128'd0);
        chk({tag, ":rsp_hold"}, 128'({rsp_rdata, rsp_timeout}),
            128'({exp_rd, exp_to}));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rdata_val = '0;
        wait_n    = 0;
        hang      = 1'b0;
        acc_cnt   = 0;

        step();
        step();
        chk("reset_ctl",
            128'({PSEL, PENABLE, PWRITE, busy, req_ready,
                  rsp_valid, rsp_timeout}),
            128'(7'b0000100));
        chk("reset_data", 128'({PADDR, PWDATA, rsp_rdata}), 128'd0);
        PRESETn = 1'b1;
        step();

        rdata_val = 32'hDEAD_BEEF;
        xfer("wr0", 1'b1, 32'h2, 32'h45, 0, 32'h0, 1'b0);

        rdata_val = 32'h54;
        xfer("rd_wait", 1'b0, 32'h3, 32'h0, 2, 32'h54, 1'b0);

        rdata_val = 32'hFFFF_FFFF;
        wait_n    = 0;
        req_write = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'hC;
        req_valid = 1'b1;
        chk("b2b:ready1", 128'(req_ready), 128'd1);
        sb.push_back('{32'h0, 1'b0, 3});
        step();
        req_addr  = 32'h2;
        req_wdata = 32'h45;
        chk("b2b:setup1", 128'({PSEL, PENABLE, req_ready}), 128'(3'b100));
        chk("b2b:bus1", 128'({PADDR, PWDATA}), 128'({32'h0, 32'hC}));
        step();
        chk("b2b:access1", 128'({PSEL, PENABLE, req_ready}), 128'(3'b110));
        chk("b2b:bus1a", 128'({PADDR, PWDATA}), 128'({32'h0, 32'hC}));
        step();
        chk("b2b:rsp1", 128'({rsp_valid, req_ready, PSEL}), 128'(3'b110));
        pop_rsp("b2b1", 3);
        sb.push_back('{32'h0, 1'b0, 3});
        step();
        req_valid = 1'b0;
        chk("b2b:setup2", 128'({PSEL, PENABLE, req_ready}), 128'(3'b100));
        chk("b2b:bus2", 128'({PWRITE, PADDR, PWDATA}),
            128'({1'b1, 32'h2, 32'h45}));
        step();
        chk("b2b:access2", 128'({PSEL, PENABLE, req_ready}), 128'(3'b110));
        step();
        chk("b2b:rsp2", 128'({rsp_valid, PSEL}), 128'(2'b10));
        pop_rsp("b2b2", 3);
        step();
        chk("b2b:pulse2", 128'(rsp_valid), 128'd0);

        hang = 1'b1;
        xfer("tmo", 1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b1);
        hang      = 1'b0;
        rdata_val = 32'h77;
        xfer("after_tmo", 1'b0, 32'h8, 32'h0, 0, 32'h77, 1'b0);

        hang      = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h5;
        req_wdata = 32'h1234;
        req_valid = 1'b1;
        chk("rst:ready", 128'(req_ready), 128'd1);
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("rst:in_access", 128'({PSEL, PENABLE}), 128'(2'b11));
        #2 PRESETn = 1'b0;
        #1;
        chk("rst:async_ctl",
            128'({PSEL, PENABLE, PWRITE, busy, req_ready,
                  rsp_valid, rsp_timeout}),
            128'(7'b0000100));
        chk("rst:async_data", 128'({PADDR, PWDATA, rsp_rdata}), 128'd0);
        step();
        chk("rst:no_rsp0", 128'(rsp_valid), 128'd0);
        step();
        chk("rst:no_rsp1", 128'(rsp_valid), 128'd0);
        void'(sb.pop_back());
        hang    = 1'b0;
        PRESETn = 1'b1;
        step();
        chk("rst:after", 128'({req_ready, busy, rsp_valid}), 128'(3'b100));
        rdata_val = 32'hA5;
        xfer("rd_after_rst", 1'b0, 32'h3, 32'h0, 1, 32'hA5, 1'b0);

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
